// File: rtl/counter_8bit_monitor.sv
// rtl/counter_8bit_monitor.sv - step checker and position extender for an 8-bit up/down counter
//
// Watches the count/overflow outputs of an 8-bit up/down counter together with
// the enable/direction that produced them. Every transition is checked while
// LOCKED. Accepted steps extend the count into an EXT_W-bit position, where the
// upper bits form a wrap epoch. The first mismatch latches FAULT until resync.
module counter_8bit_monitor #(
  parameter int EXT_W = 16,  // must be >= 9; upper EXT_W-8 bits are the wrap epoch
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obs_valid,
  input  logic             obs_dir,
  input  logic [7:0]       count_in,
  input  logic             overflow_in,
  input  logic             resync,
  output logic [EXT_W-1:0] ext_count,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked,
  output logic             fault
);

  localparam int EP_W = EXT_W - 8;
  localparam logic [EP_W-1:0]  EP_ZERO  = '0;
  localparam logic [EP_W-1:0]  EP_ONE   = {{(EP_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       CNT_ONE  = 8'd1;
  localparam logic [7:0]       CNT_MAX  = 8'hFF;
  localparam logic [7:0]       CNT_ZERO = 8'h00;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  state_e           state_q;
  logic [EXT_W-1:0] ext_q;
  logic             prev_ovf_q;
  logic             wrap_up_q;
  logic             wrap_down_q;
  logic             step_err_q;
  logic [ERR_W-1:0] err_cnt_q;

  // Views of the extended position: low byte is the last accepted count.
  logic [7:0]      prev_count;
  logic [EP_W-1:0] epoch;
  assign prev_count = ext_q[7:0];
  assign epoch      = ext_q[EXT_W-1:8];

  logic [7:0]      exp_count_d;
  logic            exp_ovf_d;
  logic            match_d;
  logic            hit_wrap_up_d;
  logic            hit_wrap_down_d;
  logic [EP_W-1:0] epoch_d;
  logic [ERR_W-1:0] err_cnt_d;

  // Predict what the counter must present this cycle given the last accepted value.
  always_comb begin
    exp_count_d     = prev_count;
    exp_ovf_d       = prev_ovf_q;
    hit_wrap_up_d   = 1'b0;
    hit_wrap_down_d = 1'b0;
    if (obs_valid) begin
      if (obs_dir) begin
        exp_count_d   = prev_count + CNT_ONE;
        hit_wrap_up_d = (prev_count == CNT_MAX);
        exp_ovf_d     = hit_wrap_up_d;
      end else begin
        exp_count_d     = prev_count - CNT_ONE;
        hit_wrap_down_d = (prev_count == CNT_ZERO);
        exp_ovf_d       = hit_wrap_down_d;
      end
    end
    match_d = (count_in == exp_count_d) && (overflow_in == exp_ovf_d);
  end

  // Epoch follows accepted wraps; error counter saturates at all-ones.
  always_comb begin
    epoch_d = epoch;
    if (hit_wrap_up_d) begin
      epoch_d = epoch + EP_ONE;
    end else if (hit_wrap_down_d) begin
      epoch_d = epoch - EP_ONE;
    end
    err_cnt_d = (&err_cnt_q) ? err_cnt_q : (err_cnt_q + ERR_ONE);
  end

  // Lock/check/fault state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNLOCKED;
      ext_q       <= '0;
      prev_ovf_q  <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      step_err_q  <= 1'b0;
      if (resync) begin
        // Resync overrides any check this cycle; err_cnt is deliberately kept.
        state_q <= ST_UNLOCKED;
      end else begin
        case (state_q)
          ST_UNLOCKED: begin
            ext_q      <= {EP_ZERO, count_in};
            prev_ovf_q <= overflow_in;
            state_q    <= ST_LOCKED;
          end
          ST_LOCKED: begin
            if (match_d) begin
              ext_q       <= {epoch_d, count_in};
              prev_ovf_q  <= overflow_in;
              wrap_up_q   <= hit_wrap_up_d;
              wrap_down_q <= hit_wrap_down_d;
            end else begin
              step_err_q <= 1'b1;
              err_cnt_q  <= err_cnt_d;
              state_q    <= ST_FAULT;
            end
          end
          ST_FAULT: begin
            state_q <= ST_FAULT;
          end
          default: begin
            state_q <= ST_UNLOCKED;
          end
        endcase
      end
    end
  end

  assign ext_count = ext_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;
  assign locked    = (state_q == ST_LOCKED);
  assign fault     = (state_q == ST_FAULT);

endmodule
